// File: rtl/mdr_mem_interface.sv
// mdr_mem_interface
//
// Memory Data Register (MDR) and Memory Address Register (MAR) for the CPU
// datapath, together with a small controller. The controller runs one
// single-word read or write at a time against external memory. Each request
// waits for an ack and gives up after a fixed number of cycles.
//
// Ports:
//   clock        rising-edge clock
//   clear_n      asynchronous active-low reset
//   bus_in       bus-mux output; loads MAR (low ADDR_W bits) and MDR
//   mar_in       load MAR from bus_in (only while idle)
//   mdr_in       load MDR from bus_in (only while idle)
//   read_start   start a memory read into MDR
//   write_start  start a memory write of MDR (read wins if both are set)
//   mem_rdata    memory read data
//   mem_ack      memory completes the outstanding request this cycle
//   mdr_out      MDR contents, fed to the bus-mux MDR input
//   mem_addr     transaction address, stable for the whole request
//   mem_wdata    write data, stable for the whole request
//   mem_rd       read request
//   mem_wr       write request
//   busy         a transaction is in progress
//   done         one-cycle completion pulse (success or timeout)
//   err_timeout  sticky; the last transaction timed out
module mdr_mem_interface #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic [31:0]       bus_in,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              read_start,
    input  logic              write_start,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       mdr_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err_timeout
);

    // Sized to hold TIMEOUT-1 even when TIMEOUT is 1.
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2
    } state_t;

    state_t            state_reg,  state_next;
    logic [ADDR_W-1:0] mar_reg,    mar_next;
    logic [31:0]       mdr_reg,    mdr_next;
    logic [ADDR_W-1:0] addr_reg,   addr_next;
    logic [31:0]       wdata_reg,  wdata_next;
    logic              rd_reg,     rd_next;
    logic              wr_reg,     wr_next;
    logic              busy_reg,   busy_next;
    logic              done_reg,   done_next;
    logic              err_reg,    err_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;

    // A load in the start cycle must reach the memory interface directly,
    // because MAR/MDR only take the new value at the same edge.
    logic [ADDR_W-1:0] start_addr;
    logic [31:0]       start_wdata;

    assign start_addr  = mar_in ? bus_in[ADDR_W-1:0] : mar_reg;
    assign start_wdata = mdr_in ? bus_in : mdr_reg;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_reg <= IDLE;
            mar_reg   <= '0;
            mdr_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            mar_reg   <= mar_next;
            mdr_reg   <= mdr_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rd_reg    <= rd_next;
            wr_reg    <= wr_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mar_next   = mar_reg;
        mdr_next   = mdr_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rd_next    = rd_reg;
        wr_next    = wr_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        err_next   = err_reg;
        cnt_next   = cnt_reg;

        unique case (state_reg)
            IDLE: begin
                // mem_ack is deliberately ignored here.
                if (mar_in) mar_next = bus_in[ADDR_W-1:0];
                if (mdr_in) mdr_next = bus_in;
                if (read_start || write_start) begin
                    addr_next = start_addr;
                    cnt_next  = '0;
                    err_next  = 1'b0;
                    busy_next = 1'b1;
                    if (read_start) begin
                        state_next = READ_WAIT;
                        rd_next    = 1'b1;
                    end else begin
                        state_next = WRITE_WAIT;
                        wr_next    = 1'b1;
                        wdata_next = start_wdata;
                    end
                end
            end

            READ_WAIT, WRITE_WAIT: begin
                // An ack in the final allowed cycle still counts as success.
                if (mem_ack || cnt_reg == CNT_LAST) begin
                    state_next = IDLE;
                    rd_next    = 1'b0;
                    wr_next    = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    if (mem_ack) begin
                        if (state_reg == READ_WAIT) mdr_next = mem_rdata;
                    end else begin
                        err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                rd_next    = 1'b0;
                wr_next    = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign mdr_out     = mdr_reg;
    assign mem_addr    = addr_reg;
    assign mem_wdata   = wdata_reg;
    assign mem_rd      = rd_reg;
    assign mem_wr      = wr_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_mdr_mem_interface.sv
// Directed testbench for mdr_mem_interface with a transaction scoreboard.
module tb_mdr_mem_interface;

    localparam int AW = 9;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          clear_n;
    logic [31:0]   bus_in;
    logic          mar_in, mdr_in, read_start, write_start;
    logic [31:0]   mem_rdata;
    logic          mem_ack;
    logic [31:0]   mdr_out;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_rd, mem_wr, busy, done, err_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit            is_rd;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   mdr;
        logic          err;
        int            cycles;
    } exp_t;

    exp_t sb[$];
    logic [AW-1:0] model_mar = '0;
    logic [31:0]   model_mdr = '0;
    int            txn_id = 0;

    mdr_mem_interface #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .bus_in      (bus_in),
        .mar_in      (mar_in),
        .mdr_in      (mdr_in),
        .read_start  (read_start),
        .write_start (write_start),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mdr_out     (mdr_out),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        mar_in      = 1'b0;
        mdr_in      = 1'b0;
        read_start  = 1'b0;
        write_start = 1'b0;
        mem_ack     = 1'b0;
        bus_in      = 32'h0;
    endtask

    // ack_at: request cycle (1 = first cycle after start) in which mem_ack is
    // driven; 0 means never. poke drives loads/starts while busy.
    task automatic do_txn(input bit rs, input bit ws, input bit lmar, input bit lmdr,
                          input logic [31:0] bus, input int ack_at,
                          input logic [31:0] rdata, input bit poke);
        exp_t e;
        exp_t g;
        int   n;
        bit   seen;
        bit   ok;
        ok = (ack_at >= 1) && (ack_at <= TO);
        if (lmar) model_mar = bus[AW-1:0];
        if (lmdr) model_mdr = bus;
        e.is_rd  = rs;
        e.addr   = model_mar;
        e.wdata  = model_mdr;
        e.cycles = ok ? ack_at : TO;
        e.err    = !ok;
        if (rs && ok) model_mdr = rdata;
        e.mdr = model_mdr;
        sb.push_back(e);

        read_start  = rs;
        write_start = ws;
        mar_in      = lmar;
        mdr_in      = lmdr;
        bus_in      = bus;
        step();
        idle_inputs();
        chk("start_busy", busy, 1);
        chk("start_rd", mem_rd, rs);
        chk("start_wr", mem_wr, !rs);
        chk("start_addr", mem_addr, e.addr);
        chk("start_err_clr", err_timeout, 0);
        if (!rs) chk("start_wdata", mem_wdata, e.wdata);
        if (lmdr) chk("start_mdr_load", mdr_out, bus);

        n = 1;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (poke) begin
                mar_in     = 1'b1;
                mdr_in     = 1'b1;
                read_start = 1'b1;
                bus_in     = 32'hFFFF_FFFF;
            end
            if (n == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata;
            end else begin
                mem_rdata = 32'hBAD0_0000 | 32'(n);
            end
            step();
            idle_inputs();
            if (done) seen = 1;
            else begin
                n++;
                chk("hold_req", rs ? mem_rd : mem_wr, 1);
                chk("hold_addr", mem_addr, e.addr);
            end
        end
        chk("done_seen", seen, 1);
        g = sb.pop_front();
        if (seen) begin
            chk("req_cycles", n, g.cycles);
            chk("end_mdr", mdr_out, g.mdr);
            chk("end_err", err_timeout, g.err);
            chk("end_busy", busy, 0);
            chk("end_rd", mem_rd, 0);
            chk("end_wr", mem_wr, 0);
            step();
            chk("done_one_cycle", done, 0);
            chk("err_sticky", err_timeout, g.err);
            chk("idle_mdr", mdr_out, g.mdr);
        end
        $display("txn %0d: %s addr=%h mdr=%h err=%0d cycles=%0d", txn_id,
                 rs ? "READ " : "WRITE", g.addr, mdr_out, err_timeout, n);
        txn_id++;
    endtask

    initial begin
        clear_n   = 1'b0;
        mem_rdata = 32'h0;
        idle_inputs();
        #23;
        chk("rst_mdr", mdr_out, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_timeout, 0);
        $display("reset: mdr=%h busy=%0d", mdr_out, busy);
        clear_n = 1'b1;
        step();

        // Ack while idle must do nothing.
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        step();
        idle_inputs();
        chk("idle_ack_mdr", mdr_out, 0);
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_done", done, 0);
        $display("idle ack: mdr=%h done=%0d", mdr_out, done);

        // Load MAR, then read with ack in the third request cycle.
        bus_in = 32'h0000_0055;
        mar_in = 1'b1;
        step();
        idle_inputs();
        model_mar = 9'h055;
        chk("mar_load_no_busy", busy, 0);
        do_txn(1, 0, 0, 0, 32'h0, 3, 32'hDEAD_BEEF, 0);

        // Write with same-cycle MDR load, ack in the first request cycle.
        do_txn(0, 1, 0, 1, 32'h1234_5678, 1, 32'h0, 0);

        // Timeout with loads/starts poked while busy.
        do_txn(1, 0, 0, 0, 32'h0, 0, 32'h0, 1);

        // Read and write together: read wins; ack on the final cycle succeeds.
        do_txn(1, 1, 1, 0, 32'h0000_01A3, TO, 32'hA5A5_5A5A, 0);

        // Timeout on a write, then recover with a write that acks late.
        do_txn(0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        do_txn(0, 1, 1, 1, 32'h8765_4321, 7, 32'h0, 1);

        // Reset in the middle of a read.
        read_start = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        chk("pre_rst_rd", mem_rd, 1);
        clear_n = 1'b0;
        #1;
        chk("mid_rst_rd", mem_rd, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mdr", mdr_out, 0);
        chk("mid_rst_err", err_timeout, 0);
        chk("mid_rst_done", done, 0);
        $display("mid reset: rd=%0d busy=%0d mdr=%h", mem_rd, busy, mdr_out);
        step();
        clear_n = 1'b1;
        step();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
